mem_bus_arbiter: RTL

- Two-master, one-slave arbiter for the native picorv32 memory interface (valid/ready/addr/wdata/wstrb/rdata).
- Shares the SoC slave bus (RAM, ROM/spimemio, UART, GPIO decode) between the CPU (master 0) and a DMA/debug master (master 1).
- Round-robin grant, no preemption. A per-transaction watchdog completes any stalled access with an error word so neither master hangs forever.

---
 rtl/mem_bus_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus.
// A per-transaction watchdog ends stalled accesses with an error word.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [7:0]  timeout_count,
  output logic [31:0] timeout_addr
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned TW = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BUSY0 = 3'd1;
  localparam logic [2:0] ST_BUSY1 = 3'd2;
  localparam logic [2:0] ST_ERR0  = 3'd3;
  localparam logic [2:0] ST_ERR1  = 3'd4;

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] CNT_MAX  = '1;

  logic [2:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [TW-1:0] timeout_count_q, timeout_count_d;
  logic [AW-1:0] timeout_addr_q, timeout_addr_d;

  // Master currently owning the bus (BUSY1/ERR1 select master 1).
  logic          sel;
  logic          sel_valid;
  logic [AW-1:0] sel_addr;

  assign sel       = (state_q == ST_BUSY1) || (state_q == ST_ERR1);
  assign sel_valid = sel ? m1_valid : m0_valid;
  assign sel_addr  = sel ? m1_addr  : m0_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= 1'b1;
      tmo_cnt_q       <= '0;
      timeout_count_q <= '0;
      timeout_addr_q  <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      tmo_cnt_q       <= tmo_cnt_d;
      timeout_count_q <= timeout_count_d;
      timeout_addr_q  <= timeout_addr_d;
    end
  end

  // Next state: s_ready beats the watchdog when both land on the same edge.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    tmo_cnt_d       = tmo_cnt_q;
    timeout_count_d = timeout_count_q;
    timeout_addr_d  = timeout_addr_q;
    case (state_q)
      ST_IDLE: begin
        tmo_cnt_d = '0;
        if (m0_valid && m1_valid) begin
          state_d = last_grant_q ? ST_BUSY0 : ST_BUSY1;
        end else if (m0_valid) begin
          state_d = ST_BUSY0;
        end else if (m1_valid) begin
          state_d = ST_BUSY1;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        if (s_ready) begin
          state_d      = ST_IDLE;
          last_grant_d = sel;
          tmo_cnt_d    = '0;
        end else if (!sel_valid) begin
          state_d   = ST_IDLE;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d        = sel ? ST_ERR1 : ST_ERR0;
          tmo_cnt_d      = '0;
          timeout_addr_d = sel_addr;
          if (timeout_count_q != CNT_MAX) begin
            timeout_count_d = timeout_count_q + TW'(1);
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
      end
      ST_ERR0, ST_ERR1: begin
        state_d      = ST_IDLE;
        last_grant_d = sel;
        tmo_cnt_d    = '0;
      end
      default: begin
        state_d   = ST_IDLE;
        tmo_cnt_d = '0;
      end
    endcase
  end

  // Bus steering; an aborting reset hides any ready from the current owner.
  always_comb begin
    s_valid  = 1'b0;
    s_instr  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_rdata = '0;
    if (!reset) begin
      case (state_q)
        ST_BUSY0: begin
          s_valid  = m0_valid;
          s_instr  = m0_instr;
          s_addr   = m0_addr;
          s_wdata  = m0_wdata;
          s_wstrb  = m0_wstrb;
          m0_ready = s_ready;
          m0_rdata = s_rdata;
        end
        ST_BUSY1: begin
          s_valid  = m1_valid;
          s_instr  = m1_instr;
          s_addr   = m1_addr;
          s_wdata  = m1_wdata;
          s_wstrb  = m1_wstrb;
          m1_ready = s_ready;
          m1_rdata = s_rdata;
        end
        ST_ERR0: begin
          m0_ready = 1'b1;
          m0_rdata = ERR_RDATA;
        end
        ST_ERR1: begin
          m1_ready = 1'b1;
          m1_rdata = ERR_RDATA;
        end
        default: begin
          s_valid = 1'b0;
        end
      endcase
    end
  end

  assign timeout_count = timeout_count_q;
  assign timeout_addr  = timeout_addr_q;

endmodule
